// File: rtl/sdf_r2_stage_ctrl_pkg.sv
// sdf_pkg: butterfly mode and sequencer state encodings shared by the SDF radix-2 stage.
package sdf_pkg;
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_BFLY = 2'b10
    } mode_e;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        RUN   = 2'b10,
        DRAIN = 2'b11
    } state_e;
endpackage

// File: rtl/sdf_r2_stage_ctrl_if.sv
// sdf_r2_stage_ctrl_if: sample stream in, butterfly/delay-line control out.
interface sdf_r2_stage_ctrl_if #(
    parameter int DATA_W = 15,
    parameter int TW_W   = 5
);
    logic                     valid_i;
    logic signed [DATA_W-1:0] data_in_r;
    logic signed [DATA_W-1:0] data_in_i;
    logic signed [DATA_W-1:0] data_out_r;
    logic signed [DATA_W-1:0] data_out_i;
    logic [1:0]               mode;
    logic                     sr_en;
    logic [TW_W-1:0]          tw_idx;
    logic                     valid_o;
    logic                     busy;
    modport master (
        output valid_i, data_in_r, data_in_i,
        input  data_out_r, data_out_i, mode, sr_en, tw_idx, valid_o, busy
    );
    modport slave (
        input  valid_i, data_in_r, data_in_i,
        output data_out_r, data_out_i, mode, sr_en, tw_idx, valid_o, busy
    );
endinterface

// File: rtl/sdf_r2_stage_ctrl_frame_cnt.sv
// sdf_frame_cnt: position within a 2*DEPTH frame; ph is the half, lo the offset in it.
module sdf_frame_cnt #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(2 * DEPTH),
    localparam int LW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          clr_i,
    output logic          ph_o,
    output logic          wrap_o,
    output logic [LW-1:0] lo_o
);
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst || clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + 1'b1;
    end
    assign ph_o   = cnt_q[CW-1];
    assign lo_o   = DEPTH > 1 ? cnt_q[LW-1:0] : '0;
    assign wrap_o = en_i && (&cnt_q);
endmodule

// File: rtl/sdf_r2_stage_ctrl.sv
// sdf_r2_stage_ctrl: sequencer for one radix-2 SDF FFT stage (butterfly mode, delay-line
// enable, twiddle index, output valid, end-of-burst drain of the feedback register).
module sdf_r2_stage_ctrl
    import sdf_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 15,
    parameter int TW_W      = 5,
    parameter int TW_STRIDE = 4
) (
    input logic clk,
    input logic rst,
    sdf_r2_stage_ctrl_if.slave bus
);
    localparam int LW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    state_e                   state_q, state_d;
    mode_e                    mode;
    logic                     v_q, pend_q, pend_d;
    logic signed [DATA_W-1:0] dr_q, di_q;
    logic                     ph, wrap, last, drain, sr_en, valid_o, busy;
    logic [LW-1:0]            lo;
    logic [TW_W-1:0]          tw_idx;
    sdf_frame_cnt #(.DEPTH(DEPTH)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (sr_en),
        .clr_i (drain && last),
        .ph_o  (ph),
        .wrap_o(wrap),
        .lo_o  (lo)
    );
    assign last  = lo == LW'(DEPTH - 1);
    assign drain = state_q == DRAIN;
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= 1'b0;
            pend_q <= 1'b0;
            dr_q   <= '0;
            di_q   <= '0;
        end else begin
            v_q    <= bus.valid_i;
            pend_q <= pend_d;
            dr_q   <= bus.data_in_r;
            di_q   <= bus.data_in_i;
        end
    end
    // Drain is decided one cycle early from the raw valid, so it starts right after the wrap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, FILL: state_d = v_q ? (last ? RUN : FILL) : state_q;
            RUN:        state_d = (wrap && !bus.valid_i) ? DRAIN : RUN;
            DRAIN:      state_d = last ? IDLE : DRAIN;
            default:    state_d = IDLE;
        endcase
    end
    always_comb begin
        sr_en   = drain || v_q;
        mode    = drain ? MODE_LOAD : !v_q ? MODE_HOLD : (state_q == RUN && ph) ? MODE_BFLY : MODE_LOAD;
        valid_o = drain || (v_q && state_q == RUN);
        tw_idx  = (mode == MODE_LOAD && valid_o) ? TW_W'(32'(lo) * TW_STRIDE) : '0;
        pend_d  = (mode == MODE_BFLY && last) ? 1'b1 : (mode == MODE_LOAD && last) ? 1'b0 : pend_q;
        busy    = state_q != IDLE || v_q || pend_q;
    end
    assign bus.data_out_r = dr_q;
    assign bus.data_out_i = di_q;
    assign bus.mode       = mode;
    assign bus.sr_en      = sr_en;
    assign bus.tw_idx     = tw_idx;
    assign bus.valid_o    = valid_o;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_sdf_r2_stage_ctrl.sv
// tb_sdf_r2_stage_ctrl: scoreboard bench for the SDF stage sequencer at DEPTH=4 and DEPTH=1.
module tb_sdf_r2_stage_ctrl;
    typedef struct {
        logic [1:0]        m;
        logic              vo;
        logic [4:0]        tw;
        logic              b;
        logic signed [14:0] dr;
        logic signed [14:0] di;
    } exp_t;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid_i = 1'b0;
    logic signed [14:0] din_r = '0;
    logic signed [14:0] din_i = '0;
    bit                 sel = 1'b0;
    int                 vectors = 0;
    int                 miscompares = 0;
    int                 nvalid = 0;
    exp_t               exp_q[$];
    always #5 clk = ~clk;
    sdf_r2_stage_ctrl_if #(.DATA_W(15), .TW_W(5)) b4 ();
    sdf_r2_stage_ctrl_if #(.DATA_W(15), .TW_W(5)) b1 ();
    assign b4.valid_i   = valid_i;
    assign b4.data_in_r = din_r;
    assign b4.data_in_i = din_i;
    assign b1.valid_i   = valid_i;
    assign b1.data_in_r = din_r;
    assign b1.data_in_i = din_i;
    sdf_r2_stage_ctrl #(.DEPTH(4), .DATA_W(15), .TW_W(5), .TW_STRIDE(4)) dut4 (
        .clk(clk), .rst(rst), .bus(b4.slave)
    );
    sdf_r2_stage_ctrl #(.DEPTH(1), .DATA_W(15), .TW_W(5), .TW_STRIDE(16)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );
    task automatic step(input bit v, input int d, input logic [1:0] m, input bit vo, input int tw, input bit b);
        exp_t e, g;
        logic [1:0] am;
        logic asr, avo, ab;
        logic [4:0] atw;
        logic signed [14:0] ar, ai;
        valid_i = v;
        din_r = 15'(d);
        din_i = 15'(-d);
        e.m = m;
        e.vo = vo;
        e.tw = 5'(tw);
        e.b = b;
        e.dr = rst ? '0 : din_r;
        e.di = rst ? '0 : din_i;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        am  = sel ? b1.mode : b4.mode;
        asr = sel ? b1.sr_en : b4.sr_en;
        avo = sel ? b1.valid_o : b4.valid_o;
        atw = sel ? b1.tw_idx : b4.tw_idx;
        ab  = sel ? b1.busy : b4.busy;
        ar  = sel ? b1.data_out_r : b4.data_out_r;
        ai  = sel ? b1.data_out_i : b4.data_out_i;
        if (avo) nvalid++;
        vectors += 7;
        if (am !== g.m) begin
            miscompares++;
            $display("FAIL mode t=%0t got %b want %b", $time, am, g.m);
        end
        if (asr !== (g.m != 2'b00)) begin
            miscompares++;
            $display("FAIL sr_en t=%0t got %b want %b", $time, asr, g.m != 2'b00);
        end
        if (avo !== g.vo) begin
            miscompares++;
            $display("FAIL valid_o t=%0t got %b want %b", $time, avo, g.vo);
        end
        if (atw !== g.tw) begin
            miscompares++;
            $display("FAIL tw_idx t=%0t got %0d want %0d", $time, atw, g.tw);
        end
        if (ab !== g.b) begin
            miscompares++;
            $display("FAIL busy t=%0t got %b want %b", $time, ab, g.b);
        end
        if (ar !== g.dr) begin
            miscompares++;
            $display("FAIL data_out_r t=%0t got %0d want %0d", $time, ar, g.dr);
        end
        if (ai !== g.di) begin
            miscompares++;
            $display("FAIL data_out_i t=%0t got %0d want %0d", $time, ai, g.di);
        end
    endtask
    // One burst of nfr frames with an optional stall before sample index stall_at,
    // followed by drain_n drain cycles (and an idle check when the drain completes).
    task automatic frames(input int d, input int st, input int nfr, input int stall_at, input int stall_n, input int drain_n);
        int n = nfr * 2 * d;
        nvalid = 0;
        for (int s = 0; s < n; s++) begin
            int pos = s % (2 * d);
            if (s == stall_at) begin
                for (int k = 0; k < stall_n; k++) step(1'b0, 0, 2'b00, 1'b0, 0, 1'b1);
                if (!sel) begin
                    vectors++;
                    if (dut4.u_cnt.cnt_q !== 3'(stall_at % (2 * d))) begin
                        miscompares++;
                        $display("FAIL stall_cnt got %0d want %0d", dut4.u_cnt.cnt_q, stall_at % (2 * d));
                    end
                end
            end
            if (s < d) step(1'b1, s + 1, 2'b01, 1'b0, 0, 1'b1);
            else if (pos >= d) step(1'b1, s + 1, 2'b10, 1'b1, 0, 1'b1);
            else step(1'b1, s + 1, 2'b01, 1'b1, (pos * st) % 32, 1'b1);
        end
        for (int k = 0; k < drain_n; k++) step(1'b0, 0, 2'b01, 1'b1, (k * st) % 32, 1'b1);
        if (drain_n == d) begin
            step(1'b0, 0, 2'b00, 1'b0, 0, 1'b0);
            vectors++;
            if (nvalid !== n) begin
                miscompares++;
                $display("FAIL valid_count got %0d want %0d", nvalid, n);
            end
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(i % 2 == 0, 100 + i, 2'b00, 1'b0, 0, 1'b0);
        rst = 1'b0;
        step(1'b0, 0, 2'b00, 1'b0, 0, 1'b0);
    endtask
    task automatic test_single_frame();
        frames(4, 4, 1, -1, 0, 4);
    endtask
    task automatic test_back_to_back();
        frames(4, 4, 2, -1, 0, 4);
    endtask
    task automatic test_stall();
        frames(4, 4, 1, 5, 3, 4);
    endtask
    task automatic test_reset_mid_drain();
        frames(4, 4, 1, -1, 0, 2);
        rst = 1'b1;
        step(1'b0, 0, 2'b00, 1'b0, 0, 1'b0);
        rst = 1'b0;
        frames(4, 4, 1, -1, 0, 4);
    endtask
    task automatic test_depth1();
        rst = 1'b1;
        step(1'b0, 0, 2'b00, 1'b0, 0, 1'b0);
        rst = 1'b0;
        sel = 1'b1;
        frames(1, 16, 1, -1, 0, 1);
        frames(1, 16, 2, -1, 0, 1);
    endtask
    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_reset_mid_drain();
        test_depth1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
